// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and constants (PARITY state under UART_TX_PARITY_EN)
package uart_pkg;

   typedef enum logic [2:0] {
      UART_TX_IDLE,
      UART_TX_START,
      UART_TX_DATA,
`ifdef UART_TX_PARITY_EN
      UART_TX_PARITY,
`endif
      UART_TX_STOP
   } uart_tx_state_t;

   localparam int HALF_PER_BIT   = 2;
   localparam int UART_DATA_BITS = 8;
   localparam int UART_STOP_BITS = 1;

endpackage

// File: rtl/uart_edge_rise.sv
// rtl/uart_edge_rise.sv - registered rising-edge detector with configurable reset level
module uart_edge_rise #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sig,
   output logic rise
);

   logic sig_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sig_d <= RESET_VAL;
      else        sig_d <= sig;
   end

   // Resetting high masks an input that is already high when reset releases
   assign rise = sig & ~sig_d;

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter, optional even parity via UART_TX_PARITY_EN
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_BITS = UART_DATA_BITS,
   parameter int STOP_BITS = UART_STOP_BITS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   input  logic                 baud_rate,
   output logic                 baud_en,
   output logic                 tx,
   output logic                 tx_busy
);

   localparam int IDX_W = $clog2(DATA_BITS);

   uart_tx_state_t       state, state_d;
   logic                 half, half_d;
   logic [IDX_W-1:0]     idx, idx_d;
   logic                 stop_cnt, stop_d;
   logic [DATA_BITS-1:0] shreg, shreg_d;
   logic                 tx_d, en_d;
   logic                 rise, bit_end;
`ifdef UART_TX_PARITY_EN
   logic                 par_q, par_d;
`endif

   uart_edge_rise #(.RESET_VAL(1'b1)) u_rise (
      .clk   (clk),
      .rst_n (rst_n),
      .sig   (baud_rate),
      .rise  (rise)
   );

   assign bit_end = (state != UART_TX_IDLE) && rise && (half == 1'(HALF_PER_BIT - 1));

   always_comb begin
      state_d = state;
      half_d  = half;
      idx_d   = idx;
      stop_d  = stop_cnt;
      shreg_d = shreg;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      if (state != UART_TX_IDLE && rise) half_d = ~half;
      case (state)
         UART_TX_IDLE: begin
            if (tx_valid) begin
               shreg_d = tx_data;
               half_d  = 1'b0;
               idx_d   = '0;
               stop_d  = 1'b0;
               state_d = UART_TX_START;
`ifdef UART_TX_PARITY_EN
               par_d   = ^tx_data;
`endif
            end
         end
         UART_TX_START: begin
            if (bit_end) begin
               idx_d   = '0;
               state_d = UART_TX_DATA;
            end
         end
         UART_TX_DATA: begin
            if (bit_end) begin
               shreg_d = shreg >> 1;
               if (idx == IDX_W'(DATA_BITS - 1)) begin
                  stop_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
                  state_d = UART_TX_PARITY;
`else
                  state_d = UART_TX_STOP;
`endif
               end else begin
                  idx_d = idx + 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         UART_TX_PARITY: begin
            if (bit_end) state_d = UART_TX_STOP;
         end
`endif
         UART_TX_STOP: begin
            if (bit_end) begin
               if (stop_cnt == 1'(STOP_BITS - 1)) state_d = UART_TX_IDLE;
               else                               stop_d  = stop_cnt + 1'b1;
            end
         end
         default: state_d = UART_TX_IDLE;
      endcase

      // Line level is derived from the next state so tx and baud_en are registered
      tx_d = 1'b1;
      case (state_d)
         UART_TX_START:  tx_d = 1'b0;
         UART_TX_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
         UART_TX_PARITY: tx_d = par_d;
`endif
         default:        tx_d = 1'b1;
      endcase
      en_d = (state_d != UART_TX_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= UART_TX_IDLE;
         half     <= 1'b0;
         idx      <= '0;
         stop_cnt <= 1'b0;
         shreg    <= '0;
         tx       <= 1'b1;
         baud_en  <= 1'b0;
      end else begin
         state    <= state_d;
         half     <= half_d;
         idx      <= idx_d;
         stop_cnt <= stop_d;
         shreg    <= shreg_d;
         tx       <= tx_d;
         baud_en  <= en_d;
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) par_q <= 1'b0;
      else        par_q <= par_d;
   end
`endif

   assign tx_ready = (state == UART_TX_IDLE);
   assign tx_busy  = ~tx_ready;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx (8N1 and 8N2 instances, parity with UART_TX_PARITY_EN)
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int M   = 10;
   localparam int BIT = 4 * (M + 1);

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tx_data [2];
   logic [1:0] tx_valid = 2'b00;
   logic [1:0] tx_ready, baud_en, tx, tx_busy;
   logic [1:0] baud_rate = 2'b11;
   int         gen_cnt [2];

   int n_chk = 0;
   int n_pass = 0;

   logic rec_on = 1'b0;
   int   rec_sel = 0;
   logic cap_tx[$], cap_en[$], cap_rdy[$];

   always #5 clk = ~clk;

   uart_tx #(.DATA_BITS(8), .STOP_BITS(1)) dut (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
      .tx_ready(tx_ready[0]), .baud_rate(baud_rate[0]), .baud_en(baud_en[0]),
      .tx(tx[0]), .tx_busy(tx_busy[0])
   );

   uart_tx #(.DATA_BITS(8), .STOP_BITS(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
      .tx_ready(tx_ready[1]), .baud_rate(baud_rate[1]), .baud_en(baud_en[1]),
      .tx(tx[1]), .tx_busy(tx_busy[1])
   );

   // Baud generator model: idles high, toggles every M+1 enabled cycles
   for (genvar g = 0; g < 2; g++) begin : g_gen
      always @(posedge clk) begin
         if (!baud_en[g]) begin
            gen_cnt[g]   <= 0;
            baud_rate[g] <= 1'b1;
         end else if (gen_cnt[g] == M) begin
            gen_cnt[g]   <= 0;
            baud_rate[g] <= ~baud_rate[g];
         end else begin
            gen_cnt[g] <= gen_cnt[g] + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (rec_on) begin
         cap_tx.push_back(tx[rec_sel]);
         cap_en.push_back(baud_en[rec_sel]);
         cap_rdy.push_back(tx_ready[rec_sel]);
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
      else n_pass++;
   endtask

   task automatic chk_range(input string name, input int got, input int lo, input int hi);
      n_chk++;
      if (got < lo || got > hi) $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
      else n_pass++;
   endtask

   // Reference frame: list of line levels in transmit order, bit 0 = start bit
   function automatic logic [11:0] model_frame(input logic [7:0] d, input int stops, output int nb);
      logic bits[$];
      logic [11:0] v = '0;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(((d >> i) & 8'd1) != 0);
      if (P == 1) bits.push_back(($countones(d) % 2) == 1);
      for (int s = 0; s < stops; s++) bits.push_back(1'b1);
      nb = bits.size();
      for (int k = 0; k < nb; k++) v[k] = bits[k];
      return v;
   endfunction

   function automatic logic [11:0] table_frame(input logic [7:0] seq, input logic par,
                                               input int stops, output int nb);
      logic [11:0] v = '0;
      int k = 1;
      for (int i = 0; i < 8; i++) begin
         v[k] = seq[7-i];
         k++;
      end
      if (P == 1) begin
         v[k] = par;
         k++;
      end
      for (int s = 0; s < stops; s++) begin
         v[k] = 1'b1;
         k++;
      end
      nb = k;
      return v;
   endfunction

   task automatic clear_capture();
      cap_tx.delete();
      cap_en.delete();
      cap_rdy.delete();
   endtask

   task automatic analyze(input int from, input logic [11:0] exp, input int nb, input string name,
                          output int s, output int r);
      logic [11:0] got = '0;
      s = -1;
      r = -1;
      for (int i = from; i < cap_tx.size(); i++)
         if (s < 0 && cap_tx[i] == 1'b0) s = i;
      if (s < 1) begin
         chk({name, " start"}, 0, 1);
         return;
      end
      chk({name, " first cycle rdy/en/prev_rdy"}, {cap_rdy[s], cap_en[s], cap_rdy[s-1]}, 3'b011);
      for (int k = 0; k < nb; k++) begin
         int c = s + BIT * k + BIT / 2;
         got[k] = (c < cap_tx.size()) ? cap_tx[c] : 1'bx;
      end
      chk({name, " bits"}, got, exp);
      for (int i = s; i < cap_rdy.size(); i++)
         if (r < 0 && cap_rdy[i] == 1'b1) r = i;
      if (r < 0) chk({name, " ready return"}, 0, 1);
      else chk_range({name, " length"}, r - s, BIT * nb, BIT * nb + 2);
   endtask

   task automatic wait_ready(input int inst, input string name);
      int t = 0;
      while (!tx_ready[inst] && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (t >= 2000) chk({name, " ready timeout"}, 0, 1);
   endtask

   task automatic run_frame(input int inst, input logic [7:0] data, input logic [11:0] exp,
                            input int nb, input string name);
      int s, r, t;
      clear_capture();
      rec_sel = inst;
      @(negedge clk);
      rec_on = 1'b1;
      tx_data[inst] = data;
      tx_valid[inst] = 1'b1;
      wait_ready(inst, name);
      @(posedge clk);
      #1 tx_valid[inst] = 1'b0;
      t = 0;
      do begin
         @(negedge clk);
         tx_data[inst] = 8'($urandom);
         t++;
      end while (!tx_ready[inst] && t < 1500);
      if (t >= 1500) chk({name, " frame timeout"}, 0, 1);
      repeat (2) @(negedge clk);
      rec_on = 1'b0;
      analyze(0, exp, nb, name, s, r);
   endtask

   typedef struct {
      int         inst;
      logic [7:0] data;
      logic [7:0] seq;
      logic       par;
   } vec_t;

   vec_t tbl[6];

   initial begin
      logic [11:0] ef;
      int          nb, s1, r1, s2, r2, low_cnt;
      tx_data[0] = 8'h00;
      tx_data[1] = 8'h00;

      tbl[0] = '{0, 8'hA5, 8'hA5, 1'b0};
      tbl[1] = '{0, 8'h07, 8'hE0, 1'b1};
      tbl[2] = '{0, 8'h03, 8'hC0, 1'b0};
      tbl[3] = '{1, 8'h00, 8'h00, 1'b0};
      tbl[4] = '{0, 8'h12, 8'h48, 1'b0};
      tbl[5] = '{1, 8'h80, 8'h01, 1'b1};

      repeat (3) @(negedge clk);
      #1;
      chk("reset dut0 tx/en/rdy/busy", {tx[0], baud_en[0], tx_ready[0], tx_busy[0]}, 4'b1010);
      chk("reset dut2 tx/en/rdy/busy", {tx[1], baud_en[1], tx_ready[1], tx_busy[1]}, 4'b1010);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         ef = table_frame(tbl[i].seq, tbl[i].par, tbl[i].inst + 1, nb);
         run_frame(tbl[i].inst, tbl[i].data, ef, nb, $sformatf("table%0d", i));
      end

      for (int i = 0; i < 8; i++) begin
         int          inst = (i >= 6) ? 1 : 0;
         logic [7:0]  d = 8'($urandom);
         ef = model_frame(d, inst + 1, nb);
         run_frame(inst, d, ef, nb, $sformatf("rand%0d_%02h", i, d));
      end

      // Back-to-back: tx_valid held high across two frames
      clear_capture();
      rec_sel = 0;
      @(negedge clk);
      rec_on = 1'b1;
      tx_data[0] = 8'h01;
      tx_valid[0] = 1'b1;
      wait_ready(0, "b2b first");
      @(negedge clk);
      tx_data[0] = 8'hFF;
      @(negedge clk);
      wait_ready(0, "b2b second");
      @(posedge clk);
      #1 tx_valid[0] = 1'b0;
      @(negedge clk);
      wait_ready(0, "b2b end");
      repeat (2) @(negedge clk);
      rec_on = 1'b0;
      ef = model_frame(8'h01, 1, nb);
      analyze(0, ef, nb, "b2b frame1", s1, r1);
      ef = model_frame(8'hFF, 1, nb);
      if (r1 > 0) begin
         analyze(r1, ef, nb, "b2b frame2", s2, r2);
         low_cnt = 0;
         for (int i = r1; i < s2 && i < cap_en.size(); i++)
            if (cap_en[i] == 1'b0) low_cnt++;
         chk("b2b baud_en low cycles", low_cnt, 1);
         chk("b2b equal lengths", r2 - s2, r1 - s1);
      end

      // Reset in the middle of data bit 3
      @(negedge clk);
      tx_data[0] = 8'h3C;
      tx_valid[0] = 1'b1;
      wait_ready(0, "rst start");
      @(posedge clk);
      #1 tx_valid[0] = 1'b0;
      repeat (200) @(negedge clk);
      chk("mid-frame busy before reset", tx_busy[0], 1'b1);
      rst_n = 1'b0;
      #1;
      chk("async reset tx/en/rdy", {tx[0], baud_en[0], tx_ready[0]}, 3'b101);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      ef = model_frame(8'hC3, 1, nb);
      run_frame(0, 8'hC3, ef, nb, "after reset");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
